retire_scoreboard: RTL and testbench
====================================

// Module: retire_scoreboard
// PURPOSE
//   Parametrised in-order lockstep checker between the DATAPATH retire stream and the
//   rv32i reference-model retire stream. Succeeds the single-channel, untimed model
//   stepping in the top-level bench: buffers each side independently, compares
//   retirements pairwise, counts matches and mismatches, and flags errors.
//   Sits in the verification top beside DATAPATH; synthesizable for FPGA lockstep runs.
// PARAMETERS
//   XLEN     32    data/PC width
//   DEPTH    8     per-side FIFO entries; power of 2, >=2
//   CNT_W    16    match/mismatch counter width
//   TIMEOUT  1024  watchdog limit in cycles (used only with RSB_WATCHDOG_EN)
// PORTS
//   i_clk            in   1      clock, rising edge
//   i_rst            in   1      synchronous, active-high reset
//   i_dut_valid      in   1      DUT retire record valid
//   i_dut_pc         in   XLEN   DUT retired PC
//   i_dut_we         in   1      DUT register write enable
//   i_dut_rd         in   5      DUT destination register
//   i_dut_wdata      in   XLEN   DUT write-back data
//   o_dut_ready      out  1      DUT FIFO can accept
//   i_ref_valid/pc/we/rd/wdata   in   as DUT side; model retire record
//   o_ref_ready      out  1      model FIFO can accept
//   o_mismatch       out  1      one-cycle pulse per failed compare
//   o_mismatch_pc    out  XLEN   DUT PC of most recent mismatch
//   o_err            out  1      sticky error flag
//   o_match_cnt      out  CNT_W  passing compares
//   o_mismatch_cnt   out  CNT_W  failing compares
//   o_timeout        out  1      sticky watchdog flag
// BEHAVIOUR
//   - Reset (i_rst=1 at posedge): both FIFOs emptied; all outputs 0 except
//     o_dut_ready=o_ref_ready=1. Applies mid-operation: in-flight entries discarded.
//   - Push: record enters a FIFO on posedge with valid&&ready. ready = !full,
//     from registered occupancy; full FIFO refuses push even when popping that cycle.
//   - Compare: when both FIFOs non-empty, pop one entry from each in the same cycle.
//     Pass iff pc equal AND eff_we equal AND (eff_we=0 OR (rd, wdata) equal),
//     where eff_we = we && rd!=0 (x0 writes are don't-care).
//   - Latency: record pushed at edge N is compared at edge N+1 at the earliest;
//     o_mismatch, o_mismatch_pc and counters update at that edge (visible after N+1).
//   - Pass: o_match_cnt++. Fail: o_mismatch_cnt++, o_mismatch=1 for one cycle,
//     o_mismatch_pc <= DUT pc, o_err <= 1.
//   - Counters saturate at 2^CNT_W-1; no wrap.
//   - FIFO pointers are log2(DEPTH)+1 bits; wrap naturally; full/empty from MSB compare.
//   - Simultaneous push and compare on the same side: occupancy unchanged.
//   - One side empty: no compare, no pop; the other side keeps buffering until full.
// CONFIGURATION
//   RSB_WATCHDOG_EN defined: counter increments each cycle exactly one FIFO is
//     non-empty; cleared on any compare or reset. On reaching TIMEOUT: o_timeout <= 1
//     and o_err <= 1 (sticky until reset); counter holds.
//   Undefined: no counter logic; o_timeout tied 0; TIMEOUT unused.
// TESTING
//   1. Reset, 10 identical records both sides same cycle -> match_cnt=10, mismatch_cnt=0, o_err=0.
//   2. Record 4 DUT wdata=0x5 vs model 0x6, rd=3 -> one o_mismatch pulse,
//      mismatch_pc=record-4 PC, o_err=1; remaining records still counted as matches.
//   3. Both we=1, rd=0, wdata differ -> pass; DUT we=1 rd=0 vs model we=0 -> pass.
//   4. DEPTH=8: push 9 DUT records, no model -> o_dut_ready=0 after 8th; 9th held;
//      then 9 model records -> 9 matches, no loss.
//   5. Assert i_rst with 3 entries buffered -> FIFOs empty, counters 0, ready=1 next cycle.
//   6. RSB_WATCHDOG_EN, TIMEOUT=16: 1 DUT record, model silent -> o_timeout=1 and o_err=1
//      after 16 cycles; without the macro o_timeout stays 0.

Source files
------------

// File: rtl/retire_scoreboard.sv
// In-order lockstep checker: buffers DUT and reference-model retire records, compares pairwise,
// counts matches/mismatches. Define RSB_WATCHDOG_EN to enable the one-side-stalled watchdog.
module retire_scoreboard #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_dut_valid,
    input  logic [XLEN-1:0]  i_dut_pc,
    input  logic             i_dut_we,
    input  logic [4:0]       i_dut_rd,
    input  logic [XLEN-1:0]  i_dut_wdata,
    output logic             o_dut_ready,
    input  logic             i_ref_valid,
    input  logic [XLEN-1:0]  i_ref_pc,
    input  logic             i_ref_we,
    input  logic [4:0]       i_ref_rd,
    input  logic [XLEN-1:0]  i_ref_wdata,
    output logic             o_ref_ready,
    output logic             o_mismatch,
    output logic [XLEN-1:0]  o_mismatch_pc,
    output logic             o_err,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic [CNT_W-1:0] o_mismatch_cnt,
    output logic             o_timeout
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned RW = 2 * XLEN + 6;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_param_err
        $error("retire_scoreboard: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    function automatic logic is_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
        return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    endfunction

    logic [RW-1:0]    dut_mem_q [DEPTH];
    logic [RW-1:0]    ref_mem_q [DEPTH];
    logic [PW-1:0]    dut_wp_q, dut_wp_d, dut_rp_q, dut_rp_d;
    logic [PW-1:0]    ref_wp_q, ref_wp_d, ref_rp_q, ref_rp_d;
    logic             dut_ready_q, dut_ready_d, ref_ready_q, ref_ready_d;
    logic             mismatch_q, mismatch_d, err_q, err_d;
    logic [XLEN-1:0]  mpc_q, mpc_d;
    logic [CNT_W-1:0] match_q, match_d, mm_q, mm_d;
    logic             dut_push, ref_push, dut_empty, ref_empty, cmp, pass, wd_set;
    logic [RW-1:0]    dut_rec, ref_rec;
    logic             dut_eff_we, ref_eff_we;

    assign dut_push  = i_dut_valid && dut_ready_q;
    assign ref_push  = i_ref_valid && ref_ready_q;
    assign dut_empty = (dut_wp_q == dut_rp_q);
    assign ref_empty = (ref_wp_q == ref_rp_q);
    assign cmp       = !dut_empty && !ref_empty;

    // Record layout: {pc, we, rd, wdata}
    assign dut_rec    = dut_mem_q[dut_rp_q[AW-1:0]];
    assign ref_rec    = ref_mem_q[ref_rp_q[AW-1:0]];
    assign dut_eff_we = dut_rec[XLEN+5] && (dut_rec[XLEN+4:XLEN] != 5'd0);
    assign ref_eff_we = ref_rec[XLEN+5] && (ref_rec[XLEN+4:XLEN] != 5'd0);
    assign pass = (dut_rec[RW-1 -: XLEN] == ref_rec[RW-1 -: XLEN]) && (dut_eff_we == ref_eff_we)
                  && (!dut_eff_we || (dut_rec[XLEN+4:0] == ref_rec[XLEN+4:0]));

    always_ff @(posedge i_clk) begin
        if (dut_push) dut_mem_q[dut_wp_q[AW-1:0]] <= {i_dut_pc, i_dut_we, i_dut_rd, i_dut_wdata};
        if (ref_push) ref_mem_q[ref_wp_q[AW-1:0]] <= {i_ref_pc, i_ref_we, i_ref_rd, i_ref_wdata};
    end

    always_comb begin
        dut_wp_d    = dut_push ? dut_wp_q + PW'(1) : dut_wp_q;
        ref_wp_d    = ref_push ? ref_wp_q + PW'(1) : ref_wp_q;
        dut_rp_d    = cmp ? dut_rp_q + PW'(1) : dut_rp_q;
        ref_rp_d    = cmp ? ref_rp_q + PW'(1) : ref_rp_q;
        dut_ready_d = !is_full(dut_wp_d, dut_rp_d);
        ref_ready_d = !is_full(ref_wp_d, ref_rp_d);
        match_d     = match_q;
        mm_d        = mm_q;
        mismatch_d  = 1'b0;
        mpc_d       = mpc_q;
        err_d       = err_q || wd_set;
        if (cmp) begin
            if (pass) begin
                if (match_q != {CNT_W{1'b1}}) match_d = match_q + CNT_W'(1);
            end else begin
                if (mm_q != {CNT_W{1'b1}}) mm_d = mm_q + CNT_W'(1);
                mismatch_d = 1'b1;
                mpc_d      = dut_rec[RW-1 -: XLEN];
                err_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dut_wp_q    <= '0;
            dut_rp_q    <= '0;
            ref_wp_q    <= '0;
            ref_rp_q    <= '0;
            dut_ready_q <= 1'b1;
            ref_ready_q <= 1'b1;
            match_q     <= '0;
            mm_q        <= '0;
            mismatch_q  <= 1'b0;
            mpc_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            dut_wp_q    <= dut_wp_d;
            dut_rp_q    <= dut_rp_d;
            ref_wp_q    <= ref_wp_d;
            ref_rp_q    <= ref_rp_d;
            dut_ready_q <= dut_ready_d;
            ref_ready_q <= ref_ready_d;
            match_q     <= match_d;
            mm_q        <= mm_d;
            mismatch_q  <= mismatch_d;
            mpc_q       <= mpc_d;
            err_q       <= err_d;
        end
    end

`ifdef RSB_WATCHDOG_EN
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          timeout_q, timeout_d;

    // Counts cycles where exactly one side holds data; saturates at TIMEOUT.
    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (cmp) begin
            wd_d = '0;
        end else if ((dut_empty != ref_empty) && (wd_q != WW'(TIMEOUT))) begin
            wd_d = wd_q + WW'(1);
        end
        if (wd_d == WW'(TIMEOUT)) timeout_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign wd_set    = timeout_d;
    assign o_timeout = timeout_q;
`else
    assign wd_set    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_dut_ready    = dut_ready_q;
    assign o_ref_ready    = ref_ready_q;
    assign o_mismatch     = mismatch_q;
    assign o_mismatch_pc  = mpc_q;
    assign o_err          = err_q;
    assign o_match_cnt    = match_q;
    assign o_mismatch_cnt = mm_q;
endmodule

// File: tb/tb_retire_scoreboard.sv
// Randomized bench for retire_scoreboard against a queue-based reference model.
// Define RSB_WATCHDOG_EN for both bench and RTL to exercise the watchdog.
module tb_retire_scoreboard;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dv = 1'b0, rv = 1'b0;
    rec_t dcur = '0, rcur = '0;
    logic             dut_ready, ref_ready, mismatch, err, timeout;
    logic [XLEN-1:0]  mismatch_pc;
    logic [CNT_W-1:0] match_cnt, mismatch_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    rec_t mdq[$], mrq[$];
    int   e_match = 0, e_mm = 0, e_wd = 0;
    bit   e_pulse = 0, e_err = 0, e_to = 0;
    logic [31:0] e_mpc = '0;
    bit   d_acc, r_acc;

    rec_t dsrc[$], rsrc[$];

    always #5 clk = ~clk;

    retire_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_dut_valid(dv), .i_dut_pc(dcur.pc), .i_dut_we(dcur.we), .i_dut_rd(dcur.rd),
        .i_dut_wdata(dcur.wdata), .o_dut_ready(dut_ready),
        .i_ref_valid(rv), .i_ref_pc(rcur.pc), .i_ref_we(rcur.we), .i_ref_rd(rcur.rd),
        .i_ref_wdata(rcur.wdata), .o_ref_ready(ref_ready),
        .o_mismatch(mismatch), .o_mismatch_pc(mismatch_pc), .o_err(err),
        .o_match_cnt(match_cnt), .o_mismatch_cnt(mismatch_cnt), .o_timeout(timeout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit rec_pass(input rec_t a, input rec_t b);
        bit ea = a.we && (a.rd != 5'd0);
        bit eb = b.we && (b.rd != 5'd0);
        if (a.pc != b.pc || ea != eb) return 1'b0;
        if (!ea) return 1'b1;
        return (a.rd == b.rd) && (a.wdata == b.wdata);
    endfunction

    // Advance model and DUT by one clock, then compare all observable outputs.
    task automatic step();
        bit do_cmp, one_side;
        rec_t a, b;
        d_acc = 0;
        r_acc = 0;
        if (rst) begin
            mdq.delete(); mrq.delete();
            e_match = 0; e_mm = 0; e_wd = 0;
            e_pulse = 0; e_err = 0; e_to = 0; e_mpc = '0;
        end else begin
            d_acc    = dv && (mdq.size() < DEPTH);
            r_acc    = rv && (mrq.size() < DEPTH);
            do_cmp   = (mdq.size() > 0) && (mrq.size() > 0);
            one_side = (mdq.size() > 0) != (mrq.size() > 0);
            e_pulse  = 0;
            if (do_cmp) begin
                a = mdq.pop_front();
                b = mrq.pop_front();
                if (rec_pass(a, b)) begin
                    if (e_match < (1 << CNT_W) - 1) e_match++;
                end else begin
                    if (e_mm < (1 << CNT_W) - 1) e_mm++;
                    e_pulse = 1; e_mpc = a.pc; e_err = 1;
                end
            end
`ifdef RSB_WATCHDOG_EN
            if (do_cmp) e_wd = 0;
            else if (one_side && e_wd < TIMEOUT) e_wd++;
            if (e_wd == TIMEOUT) begin e_to = 1; e_err = 1; end
`endif
            if (d_acc) mdq.push_back(dcur);
            if (r_acc) mrq.push_back(rcur);
        end
        @(posedge clk);
        #1;
        check("dut_ready", 64'(dut_ready), 64'(mdq.size() < DEPTH));
        check("ref_ready", 64'(ref_ready), 64'(mrq.size() < DEPTH));
        check("match_cnt", 64'(match_cnt), 64'(e_match));
        check("mismatch_cnt", 64'(mismatch_cnt), 64'(e_mm));
        check("mismatch", 64'(mismatch), 64'(e_pulse));
        check("mismatch_pc", 64'(mismatch_pc), 64'(e_mpc));
        check("err", 64'(err), 64'(e_err));
        check("timeout", 64'(timeout), 64'(e_to));
    endtask

    // Offer queued records on both sides; valid is held until accepted.
    task automatic run_streams(input int pct, input int max_cycles, input bit must_drain);
        bit dh = 0, rh = 0;
        for (int c = 0; c < max_cycles; c++) begin
            if (dsrc.size() == 0 && rsrc.size() == 0) break;
            dv = (dsrc.size() > 0) && (dh || ($urandom_range(0, 99) < pct));
            rv = (rsrc.size() > 0) && (rh || ($urandom_range(0, 99) < pct));
            if (dv) dcur = dsrc[0];
            if (rv) rcur = rsrc[0];
            step();
            dh = dv && !d_acc;
            rh = rv && !r_acc;
            if (d_acc) void'(dsrc.pop_front());
            if (r_acc) void'(rsrc.pop_front());
        end
        if (must_drain) begin
            check("drain_timeout", 64'(dsrc.size() + rsrc.size()), 64'd0);
            dv = 0; rv = 0;
        end
    endtask

    task automatic idle(input int n);
        dv = 0; rv = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        dv = 0; rv = 0; rst = 1;
        step();
        rst = 0;
    endtask

    function automatic rec_t mk(input int k);
        rec_t r;
        r.pc    = 32'h1000 + 32'(k * 4);
        r.we    = 1'b1;
        r.rd    = 5'(1 + (k % 31));
        r.wdata = 32'hA000 + 32'(k);
        return r;
    endfunction

    initial begin
        rec_t r;
        do_reset();
        check("reset_match_cnt", 64'(match_cnt), 64'd0);
        check("reset_dut_ready", 64'(dut_ready), 64'd1);

        // Ten identical records presented to both sides together
        for (int k = 0; k < 10; k++) begin dsrc.push_back(mk(k)); rsrc.push_back(mk(k)); end
        run_streams(100, 40, 1);
        idle(3);
        check("t1_match", 64'(match_cnt), 64'd10);
        check("t1_err", 64'(err), 64'd0);

        // Single wdata mismatch on the fourth record
        do_reset();
        for (int k = 0; k < 10; k++) begin
            r = mk(k);
            if (k == 3) begin r.rd = 5'd3; r.wdata = 32'h5; end
            dsrc.push_back(r);
            if (k == 3) r.wdata = 32'h6;
            rsrc.push_back(r);
        end
        run_streams(100, 40, 1);
        idle(3);
        check("t2_match", 64'(match_cnt), 64'd9);
        check("t2_mm", 64'(mismatch_cnt), 64'd1);
        check("t2_mpc", 64'(mismatch_pc), 64'(mk(3).pc));

        // x0 writes are don't-care
        do_reset();
        r = mk(20); r.rd = 5'd0; r.wdata = 32'h1; dsrc.push_back(r);
        r.wdata = 32'h2; rsrc.push_back(r);
        r = mk(21); r.rd = 5'd0; dsrc.push_back(r);
        r.we = 1'b0; rsrc.push_back(r);
        run_streams(100, 20, 1);
        idle(3);
        check("t3_match", 64'(match_cnt), 64'd2);
        check("t3_err", 64'(err), 64'd0);

        // Fill the DUT FIFO with the model silent, then release
        do_reset();
        for (int k = 0; k < 9; k++) dsrc.push_back(mk(40 + k));
        run_streams(100, 12, 0);
        check("t4_full_ready", 64'(dut_ready), 64'd0);
        for (int k = 0; k < 9; k++) rsrc.push_back(mk(40 + k));
        run_streams(100, 40, 1);
        idle(4);
        check("t4_match", 64'(match_cnt), 64'd9);
        check("t4_mm", 64'(mismatch_cnt), 64'd0);

        // Reset with entries in flight
        for (int k = 0; k < 3; k++) dsrc.push_back(mk(60 + k));
        run_streams(100, 10, 1);
        do_reset();
        check("t5_ready", 64'(dut_ready), 64'd1);
        check("t5_match", 64'(match_cnt), 64'd0);
        rsrc.push_back(mk(60));
        run_streams(100, 5, 1);
        idle(2);

        // Watchdog: one side stalls
        do_reset();
        dsrc.push_back(mk(70));
        run_streams(100, 5, 1);
        idle(TIMEOUT + 4);
`ifdef RSB_WATCHDOG_EN
        check("t6_timeout", 64'(timeout), 64'd1);
        check("t6_err", 64'(err), 64'd1);
`else
        check("t6_timeout", 64'(timeout), 64'd0);
        check("t6_err", 64'(err), 64'd0);
`endif

        // Random traffic with occasional corruption on the model side
        do_reset();
        for (int k = 0; k < 120; k++) begin
            r.pc    = 32'($urandom_range(0, 15)) << 2;
            r.we    = 1'($urandom_range(0, 1));
            r.rd    = 5'($urandom_range(0, 3));
            r.wdata = 32'($urandom_range(0, 7));
            dsrc.push_back(r);
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 3))
                    0: r.pc = r.pc + 32'd4;
                    1: r.we = ~r.we;
                    2: r.rd = r.rd + 5'd1;
                    default: r.wdata = r.wdata ^ 32'h1;
                endcase
            end
            rsrc.push_back(r);
        end
        run_streams(45, 3000, 1);
        idle(4);
        check("t7_total", 64'(match_cnt + mismatch_cnt), 64'd120);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
